can_frame_sequencer: RTL and testbench
======================================

CAN_FRAME_SEQUENCER -- requirements
Module: can_frame_sequencer

Interface
REQ-001 Parameter IDLE_BITS, default 11: number of consecutive recessive bits that counts as bus idle.
REQ-002 clk  in  1  system clock; every input is synchronous to clk.
REQ-003 rst  in  1  reset, asynchronous and active-low.
REQ-004 bit_valid  in  1  one-cycle strobe; one strobe per destuffed bit.
REQ-005 rx_bit  in  1  destuffed bit value, sampled when bit_valid=1; 0 is dominant.
REQ-006 stuff_err  in  1  one-cycle pulse from the destuffer reporting a stuff violation.
REQ-007 unstuff_en  out  1  enable to the destuffer.
REQ-008 id  out  11  identifier of the current frame.
REQ-009 rtr  out  1  remote-frame flag.
REQ-010 dlc  out  4  data length code.
REQ-011 byte_out  out  8  received data byte.
REQ-012 byte_valid  out  1  one-cycle strobe that qualifies byte_out.
REQ-013 frame_done  out  1  one-cycle strobe for a good frame.
REQ-014 frame_err  out  1  one-cycle strobe for a failed frame.
REQ-015 err_code  out  3  error cause: 0 none, 1 stuff, 2 form, 3 crc, 4 ext_frame. Held until the next SOF.

Function
REQ-016 The block shall act only on cycles with bit_valid=1, except for stuff_err handling and reset.
REQ-017 States: WAIT_IDLE, IDLE, ID, RTR, IDE, R0, DLC, DATA, CRC, CRC_DEL, ACK, ACK_DEL, EOF, INTERMISSION.
- One bit counter, 7 bits wide, is shared by all states.
REQ-018 WAIT_IDLE: count consecutive rx_bit=1.
- A 0 clears the count.
- When the count reaches IDLE_BITS, go to IDLE.
REQ-019 IDLE: rx_bit=0 is SOF.
- Go to ID.
- Clear id, dlc, crc and err_code.
- Assert unstuff_en on the same edge.
REQ-020 ID: shift 11 bits MSB-first into id. Next: RTR.
REQ-021 RTR: latch rtr. Next: IDE.
REQ-022 IDE: rx_bit=1 means extended frame, which is not supported.
- Set err_code=4 and pulse frame_err.
- Go to WAIT_IDLE.
- Otherwise go to R0.
REQ-023 R0: accept either value. Next: DLC.
REQ-024 DLC: shift 4 bits MSB-first.
- Byte count = 0 if rtr=1, else min(dlc,8).
- Go to DATA if the byte count is nonzero, else CRC.
REQ-025 DATA: shift 8 bits per byte, MSB-first.
- On each 8th bit, pulse byte_valid one cycle after that bit, with byte_out held stable.
- After the last byte, go to CRC.
REQ-026 CRC-15, polynomial 0x4599, initial value 0.
- Updated on every bit from SOF to the last DATA/DLC bit, inclusive.
- CRC state shifts 15 received bits and compares them with the computed value.
- Next: CRC_DEL.
REQ-027 unstuff_en shall be 1 from the SOF edge through the last CRC bit.
- It shall deassert on the same edge that enters CRC_DEL.
- It shall be 0 in every other state.
REQ-028 CRC_DEL: the bit must be 1, else form error. ACK: accept either value. ACK_DEL: the bit must be 1, else form error.
REQ-029 EOF: 7 bits, all must be 1, else form error.
- After EOF:
  - if the CRC matches, pulse frame_done and go to INTERMISSION;
  - otherwise set err_code=3, pulse frame_err and go to INTERMISSION.
REQ-030 INTERMISSION: 3 bits.
- A 0 in the first two bits is a form error.
- A 0 in the 3rd bit is a new SOF: handle it as in REQ-019.
- After 3 ones, go to IDLE.
REQ-031 Form error: set err_code=2, pulse frame_err, deassert unstuff_en and go to WAIT_IDLE.
REQ-032 stuff_err=1 in any state from ID through CRC:
- set err_code=1, pulse frame_err and go to WAIT_IDLE;
- this takes priority over a simultaneous bit_valid.
- Outside those states, stuff_err shall be ignored.
REQ-033 At most one of frame_done, frame_err, byte_valid shall be high in any cycle.
REQ-034 dlc values 9-15 shall be reported unchanged and treated as 8 data bytes.

Reset
REQ-035 When rst=0, asynchronously:
- state=WAIT_IDLE;
- counters=0;
- id=0, rtr=0, dlc=0, byte_out=0, err_code=0, CRC=0;
- all strobes=0 and unstuff_en=0.
REQ-036 Reset asserted mid-frame shall abandon the frame with no frame_err pulse.
- After release, the block needs IDLE_BITS recessive bits before it accepts SOF.

Verification
REQ-037 Sequence:
- 11 ones, then frame id=0x123, rtr=0, dlc=2, data 0xA5,0x3C, correct CRC, ACK=0, delimiters and EOF all 1.
- Required: byte_valid twice with 0xA5 then 0x3C, then frame_done once, err_code=0, unstuff_en=0 from CRC_DEL onward.
REQ-038 Same frame with one CRC bit flipped -> frame_err at the end of EOF, err_code=3, no frame_done.
REQ-039 Frame id=0x7FF, rtr=1, dlc=5 -> no byte_valid; CRC follows DLC directly; frame_done.
REQ-040 stuff_err pulsed during the 3rd data bit -> frame_err, err_code=1, state WAIT_IDLE.
- A following SOF after fewer than 11 ones shall be ignored.
REQ-041 IDE bit=1 -> frame_err, err_code=4. CRC_DEL=0 in a separate frame -> err_code=2, unstuff_en already 0.
REQ-042 rst=0 during DATA -> all outputs zero immediately. After release, a valid frame is decoded only after 11 idle ones.

Source files
------------

// File: rtl/can_frame_sequencer.sv
// CAN 2.0A receive sequencer: walks destuffed bits through the base-frame fields, checks CRC-15 and form.
// Strobes are registered one cycle after the deciding bit; there is no backpressure, so bits arrive only as bit_valid pulses.
module can_frame_sequencer #(
    parameter int IDLE_BITS = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_valid,
    input  logic        rx_bit,
    input  logic        stuff_err,
    output logic        unstuff_en,
    output logic [10:0] id,
    output logic        rtr,
    output logic [3:0]  dlc,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    output logic        frame_done,
    output logic        frame_err,
    output logic [2:0]  err_code
);

    typedef enum logic [3:0] {
        WAIT_IDLE, IDLE, ID, RTR, IDE, R0, DLC, DATA,
        CRC, CRC_DEL, ACK, ACK_DEL, EOF, INTERMISSION
    } state_t;

    localparam logic [6:0]  IDLE_LAST = 7'(IDLE_BITS - 1);
    localparam logic [14:0] CRC_POLY  = 15'h4599;
    localparam logic [2:0]  ERR_NONE  = 3'd0;
    localparam logic [2:0]  ERR_STUFF = 3'd1;
    localparam logic [2:0]  ERR_FORM  = 3'd2;
    localparam logic [2:0]  ERR_CRC   = 3'd3;
    localparam logic [2:0]  ERR_EXT   = 3'd4;

    state_t      state, state_nxt;
    logic [6:0]  cnt;
    logic [14:0] crc, crc_rx;
    logic [6:0]  data_sr;
    logic [3:0]  dlc_shift, nbytes, nbytes_dlc;
    logic        in_frame, stuff_abort, sof, form_err, ext_err, eof_end, data_last, crc_bit;

    function automatic logic [3:0] byte_count(input logic r, input logic [3:0] d);
        if (r)              return 4'd0;
        else if (d > 4'd8)  return 4'd8;
        else                return d;
    endfunction

    function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
        return {c[13:0], 1'b0} ^ ((b ^ c[14]) ? CRC_POLY : 15'd0);
    endfunction

    // dlc_shift is the DLC value including the bit being sampled now
    assign dlc_shift  = {dlc[2:0], rx_bit};
    assign nbytes     = byte_count(rtr, dlc);
    assign nbytes_dlc = byte_count(rtr, dlc_shift);
    assign data_last  = (cnt[2:0] == 3'd7) && (cnt[6:3] == (nbytes - 4'd1));
    assign crc_bit    = state inside {ID, RTR, IDE, R0, DLC, DATA};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= WAIT_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        sof         = 1'b0;
        form_err    = 1'b0;
        ext_err     = 1'b0;
        eof_end     = 1'b0;
        in_frame    = state inside {ID, RTR, IDE, R0, DLC, DATA, CRC};
        stuff_abort = stuff_err && in_frame;
        if (stuff_abort) begin
            state_nxt = WAIT_IDLE;
        end else if (bit_valid) begin
            case (state)
                WAIT_IDLE: if (rx_bit && cnt == IDLE_LAST) state_nxt = IDLE;
                IDLE: if (!rx_bit) begin
                    sof       = 1'b1;
                    state_nxt = ID;
                end
                ID:  if (cnt == 7'd10) state_nxt = RTR;
                RTR: state_nxt = IDE;
                IDE: if (rx_bit) begin
                    ext_err   = 1'b1;
                    state_nxt = WAIT_IDLE;
                end else begin
                    state_nxt = R0;
                end
                R0:  state_nxt = DLC;
                DLC: if (cnt == 7'd3) state_nxt = (nbytes_dlc != 4'd0) ? DATA : CRC;
                DATA: if (data_last) state_nxt = CRC;
                CRC: if (cnt == 7'd14) state_nxt = CRC_DEL;
                CRC_DEL: if (rx_bit) state_nxt = ACK;
                         else begin form_err = 1'b1; state_nxt = WAIT_IDLE; end
                ACK: state_nxt = ACK_DEL;
                ACK_DEL: if (rx_bit) state_nxt = EOF;
                         else begin form_err = 1'b1; state_nxt = WAIT_IDLE; end
                EOF: if (!rx_bit) begin
                    form_err  = 1'b1;
                    state_nxt = WAIT_IDLE;
                end else if (cnt == 7'd6) begin
                    eof_end   = 1'b1;
                    state_nxt = INTERMISSION;
                end
                // A dominant third intermission bit is an immediate SOF
                INTERMISSION: if (!rx_bit) begin
                    if (cnt == 7'd2) begin
                        sof       = 1'b1;
                        state_nxt = ID;
                    end else begin
                        form_err  = 1'b1;
                        state_nxt = WAIT_IDLE;
                    end
                end else if (cnt == 7'd2) begin
                    state_nxt = IDLE;
                end
                default: state_nxt = WAIT_IDLE;
            endcase
        end
    end

    always_comb begin
        unstuff_en = in_frame;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            id         <= '0;
            rtr        <= 1'b0;
            dlc        <= '0;
            byte_out   <= '0;
            data_sr    <= '0;
            crc        <= '0;
            crc_rx     <= '0;
            err_code   <= ERR_NONE;
            byte_valid <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (stuff_abort) begin
                cnt       <= '0;
                err_code  <= ERR_STUFF;
                frame_err <= 1'b1;
            end else if (bit_valid) begin
                if (state_nxt != state || (state == WAIT_IDLE && !rx_bit)) cnt <= '0;
                else                                                        cnt <= cnt + 7'd1;
                if (crc_bit) crc <= crc_step(crc, rx_bit);
                if (sof) begin
                    id       <= '0;
                    dlc      <= '0;
                    crc      <= '0;
                    err_code <= ERR_NONE;
                end
                if (ext_err) begin
                    err_code  <= ERR_EXT;
                    frame_err <= 1'b1;
                end
                if (form_err) begin
                    err_code  <= ERR_FORM;
                    frame_err <= 1'b1;
                end
                if (eof_end) begin
                    if (crc_rx == crc) frame_done <= 1'b1;
                    else begin
                        err_code  <= ERR_CRC;
                        frame_err <= 1'b1;
                    end
                end
                case (state)
                    ID:  id  <= {id[9:0], rx_bit};
                    RTR: rtr <= rx_bit;
                    DLC: dlc <= dlc_shift;
                    DATA: begin
                        data_sr <= {data_sr[5:0], rx_bit};
                        if (cnt[2:0] == 3'd7) begin
                            byte_out   <= {data_sr, rx_bit};
                            byte_valid <= 1'b1;
                        end
                    end
                    CRC: crc_rx <= {crc_rx[13:0], rx_bit};
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_can_frame_sequencer.sv
// Directed-frame bench: stimulus pushes expected strobes into a scoreboard queue, a negedge monitor pops and compares.
module tb_can_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        bit_valid, rx_bit, stuff_err;
    logic        unstuff_en;
    logic [10:0] id;
    logic        rtr;
    logic [3:0]  dlc;
    logic [7:0]  byte_out;
    logic        byte_valid, frame_done, frame_err;
    logic [2:0]  err_code;

    always #5 clk = ~clk;

    can_frame_sequencer #(.IDLE_BITS(11)) dut (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .rx_bit(rx_bit), .stuff_err(stuff_err),
        .unstuff_en(unstuff_en), .id(id), .rtr(rtr), .dlc(dlc), .byte_out(byte_out),
        .byte_valid(byte_valid), .frame_done(frame_done), .frame_err(frame_err), .err_code(err_code)
    );

    typedef struct {
        int          kind;   // 0 byte, 1 frame_done, 2 frame_err
        logic [7:0]  b;
        logic [10:0] fid;
        logic [3:0]  fdlc;
        logic        frtr;
        logic [2:0]  ec;
    } ev_t;

    ev_t        sb[$];
    ev_t        mon_e;
    int         n_checks = 0;
    int         n_fail   = 0;
    bit         frm[$];
    int         crc_last_idx;
    logic [7:0] dbytes [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_byte(input logic [7:0] b);
        ev_t e;
        e = '{kind: 0, b: b, fid: 11'd0, fdlc: 4'd0, frtr: 1'b0, ec: 3'd0};
        sb.push_back(e);
    endtask

    task automatic exp_done(input logic [10:0] fid, input logic [3:0] fdlc, input logic frtr);
        ev_t e;
        e = '{kind: 1, b: 8'd0, fid: fid, fdlc: fdlc, frtr: frtr, ec: 3'd0};
        sb.push_back(e);
    endtask

    task automatic exp_err(input logic [2:0] ec);
        ev_t e;
        e = '{kind: 2, b: 8'd0, fid: 11'd0, fdlc: 4'd0, frtr: 1'b0, ec: ec};
        sb.push_back(e);
    endtask

    // Remainder of M(x)*x^15 modulo x^15+x^14+x^10+x^8+x^7+x^4+x^3+1 by long division
    function automatic logic [14:0] ref_crc(input int nbits);
        logic [15:0] rem;
        bit          m;
        rem = 16'd0;
        for (int i = 0; i < nbits + 15; i++) begin
            m   = (i < nbits) ? frm[i] : 1'b0;
            rem = {rem[14:0], m};
            if (rem[15]) rem = rem ^ 16'hC599;
        end
        return rem[14:0];
    endfunction

    task automatic build(input logic [10:0] fid, input logic frtr, input logic [3:0] fdlc);
        int          nb;
        logic [14:0] c;
        frm.delete();
        frm.push_back(1'b0);
        for (int i = 10; i >= 0; i--) frm.push_back(fid[i]);
        frm.push_back(frtr);
        frm.push_back(1'b0);
        frm.push_back(1'b0);
        for (int i = 3; i >= 0; i--) frm.push_back(fdlc[i]);
        nb = frtr ? 0 : ((fdlc > 4'd8) ? 8 : int'(fdlc));
        for (int b = 0; b < nb; b++)
            for (int i = 7; i >= 0; i--) frm.push_back(dbytes[b][i]);
        c = ref_crc(frm.size());
        for (int i = 14; i >= 0; i--) frm.push_back(c[i]);
        crc_last_idx = frm.size() - 1;
        frm.push_back(1'b1);
        frm.push_back(1'b0);
        frm.push_back(1'b1);
        repeat (10) frm.push_back(1'b1);
    endtask

    task automatic send_bit(input logic b, input logic serr);
        rx_bit    = b;
        bit_valid = 1'b1;
        stuff_err = serr;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        stuff_err = 1'b0;
        rx_bit    = 1'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic ones(input int n);
        repeat (n) send_bit(1'b1, 1'b0);
    endtask

    // en_mode 1: frame is accepted, unstuff_en follows the frame; 2: frame is ignored, unstuff_en stays 0
    task automatic send_frame(input int upto, input int stuff_at, input int en_mode);
        for (int i = 0; i <= upto; i++) begin
            if (en_mode == 1)
                chk("unstuff_en", 32'(unstuff_en), (i >= 1 && i <= crc_last_idx) ? 32'd1 : 32'd0);
            else if (en_mode == 2)
                chk("unstuff_en_ignored", 32'(unstuff_en), 32'd0);
            send_bit(frm[i], i == stuff_at);
        end
    endtask

    always @(negedge clk) begin
        if (rst && (byte_valid || frame_done || frame_err)) begin
            chk("strobe_onehot", 32'($onehot({byte_valid, frame_done, frame_err})), 32'd1);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: got bv=%0b fd=%0b fe=%0b err_code=%0d, expected no strobe at %0t",
                         byte_valid, frame_done, frame_err, err_code, $time);
            end else begin
                mon_e = sb.pop_front();
                case (mon_e.kind)
                    0: begin
                        chk("byte_valid", 32'(byte_valid), 32'd1);
                        chk("byte_out", 32'(byte_out), 32'(mon_e.b));
                    end
                    1: begin
                        chk("frame_done", 32'(frame_done), 32'd1);
                        chk("done_id", 32'(id), 32'(mon_e.fid));
                        chk("done_dlc", 32'(dlc), 32'(mon_e.fdlc));
                        chk("done_rtr", 32'(rtr), 32'(mon_e.frtr));
                        chk("done_err_code", 32'(err_code), 32'd0);
                    end
                    default: begin
                        chk("frame_err", 32'(frame_err), 32'd1);
                        chk("err_code", 32'(err_code), 32'(mon_e.ec));
                    end
                endcase
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "time limit reached");
    end

    initial begin
        rst       = 1'b0;
        bit_valid = 1'b0;
        rx_bit    = 1'b1;
        stuff_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_id", 32'(id), 32'd0);
        chk("rst_dlc", 32'(dlc), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_unstuff_en", 32'(unstuff_en), 32'd0);
        chk("rst_strobes", 32'({byte_valid, frame_done, frame_err}), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        ones(11);

        // Good data frame
        dbytes[0] = 8'hA5;
        dbytes[1] = 8'h3C;
        build(11'h123, 1'b0, 4'd2);
        exp_byte(8'hA5);
        exp_byte(8'h3C);
        exp_done(11'h123, 4'd2, 1'b0);
        send_frame(frm.size() - 1, -1, 1);
        chk("good_err_code", 32'(err_code), 32'd0);
        chk("good_unstuff_after", 32'(unstuff_en), 32'd0);

        // Corrupted CRC field
        build(11'h123, 1'b0, 4'd2);
        frm[crc_last_idx - 3] = ~frm[crc_last_idx - 3];
        exp_byte(8'hA5);
        exp_byte(8'h3C);
        exp_err(3'd3);
        send_frame(frm.size() - 1, -1, 1);
        chk("crc_err_code_held", 32'(err_code), 32'd3);

        // Remote frame: no data bytes even though dlc is nonzero
        build(11'h7FF, 1'b1, 4'd5);
        exp_done(11'h7FF, 4'd5, 1'b1);
        send_frame(frm.size() - 1, -1, 1);

        // stuff_err outside a frame is ignored
        stuff_err = 1'b1;
        @(posedge clk);
        #1;
        stuff_err = 1'b0;
        send_bit(1'b1, 1'b1);
        chk("idle_stuff_err_code", 32'(err_code), 32'd0);
        chk("idle_stuff_unstuff", 32'(unstuff_en), 32'd0);

        // dlc above 8 carries eight bytes and is reported unchanged
        dbytes[0] = 8'h01; dbytes[1] = 8'h80; dbytes[2] = 8'hFF; dbytes[3] = 8'h00;
        dbytes[4] = 8'h5A; dbytes[5] = 8'hC3; dbytes[6] = 8'h7E; dbytes[7] = 8'h81;
        build(11'h555, 1'b0, 4'd12);
        for (int b = 0; b < 8; b++) exp_byte(dbytes[b]);
        exp_done(11'h555, 4'd12, 1'b0);
        send_frame(frm.size() - 1, -1, 1);

        // Stuff error on the third data bit, then a frame after too few idle bits
        dbytes[0] = 8'hA5;
        dbytes[1] = 8'h3C;
        build(11'h123, 1'b0, 4'd2);
        exp_err(3'd1);
        send_frame(21, 21, 1);
        chk("stuff_unstuff_off", 32'(unstuff_en), 32'd0);
        chk("stuff_err_code", 32'(err_code), 32'd1);
        ones(5);
        send_frame(frm.size() - 1, -1, 2);
        chk("ignored_err_code", 32'(err_code), 32'd1);

        // Extended-frame IDE bit
        build(11'h123, 1'b0, 4'd2);
        frm[13] = 1'b1;
        exp_err(3'd4);
        send_frame(13, -1, 1);
        chk("ide_err_code", 32'(err_code), 32'd4);
        ones(11);

        // Dominant CRC delimiter
        build(11'h123, 1'b0, 4'd2);
        frm[crc_last_idx + 1] = 1'b0;
        exp_byte(8'hA5);
        exp_byte(8'h3C);
        exp_err(3'd2);
        send_frame(crc_last_idx + 1, -1, 1);
        chk("form_err_code", 32'(err_code), 32'd2);
        ones(11);

        // Reset in the middle of the data field
        build(11'h123, 1'b0, 4'd2);
        exp_byte(8'hA5);
        send_frame(28, -1, 1);
        rst = 1'b0;
        #2;
        chk("midrst_id", 32'(id), 32'd0);
        chk("midrst_byte_out", 32'(byte_out), 32'd0);
        chk("midrst_dlc", 32'(dlc), 32'd0);
        chk("midrst_err_code", 32'(err_code), 32'd0);
        chk("midrst_unstuff", 32'(unstuff_en), 32'd0);
        chk("midrst_strobes", 32'({byte_valid, frame_done, frame_err}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        send_frame(frm.size() - 1, -1, 2);
        exp_byte(8'hA5);
        exp_byte(8'h3C);
        exp_done(11'h123, 4'd2, 1'b0);
        send_frame(frm.size() - 1, -1, 1);

        ones(3);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
